// File: rtl/datapath_pkg.sv
// Shared definitions for the RV32I execution datapath: widths, ALU opcodes, flag bundle.
package datapath_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_AND  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;

    typedef struct packed {
        logic c;
        logic v;
        logic n;
        logic z;
    } flags_t;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: ten RV32I operations plus opB pass-through, with C/V/N/Z flags.
module datapath_alu
    import datapath_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic [3:0]   sel,
    output logic [W-1:0] result,
    output flags_t       flags
);

    localparam int SHW = $clog2(W);

    logic [W:0]     sum;
    logic [W:0]     diff;
    logic [SHW-1:0] shamt;

    // Compare ops share the subtractor so C reports "no borrow" for them too.
    assign sum   = {1'b0, op_a} + {1'b0, op_b};
    assign diff  = {1'b0, op_a} + {1'b0, ~op_b} + {{W{1'b0}}, 1'b1};
    assign shamt = op_b[SHW-1:0];

    always_comb begin
        result  = op_b;
        flags.c = 1'b0;
        flags.v = 1'b0;
        case (sel)
            ALU_ADD: begin
                result  = sum[W-1:0];
                flags.c = sum[W];
                flags.v = (op_a[W-1] == op_b[W-1]) && (sum[W-1] != op_a[W-1]);
            end
            ALU_SUB: begin
                result  = diff[W-1:0];
                flags.c = diff[W];
                flags.v = (op_a[W-1] != op_b[W-1]) && (diff[W-1] != op_a[W-1]);
            end
            ALU_SLT: begin
                result  = {{(W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
                flags.c = diff[W];
            end
            ALU_SLTU: begin
                result  = {{(W-1){1'b0}}, (op_a < op_b)};
                flags.c = diff[W];
            end
            ALU_XOR: result = op_a ^ op_b;
            ALU_OR:  result = op_a | op_b;
            ALU_AND: result = op_a & op_b;
            ALU_SLL: result = op_a << shamt;
            ALU_SRL: result = op_a >> shamt;
            ALU_SRA: result = $unsigned($signed(op_a) >>> shamt);
            default: result = op_b;
        endcase
        flags.n = result[W-1];
        flags.z = (result == '0);
    end

endmodule

// File: rtl/datapath_core.sv
// Single-cycle RV32I datapath: register file, operand muxes, ALU and write-back mux.
// Define DATAPATH_FLAGS_REG_EN to register C/V/N/Z on cycles with we=1.
module datapath_core
    import datapath_pkg::*;
#(
    parameter int size = DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic                     MB_select,
    input  logic                     MD_select,
    input  logic                     MR_select,
    input  logic [3:0]               Sel,
    input  logic [$clog2(size)-1:0]  A_select,
    input  logic [$clog2(size)-1:0]  B_select,
    input  logic [$clog2(size)-1:0]  D_addr,
    input  logic [size-1:0]          PC_in,
    input  logic [size-1:0]          Data_in,
    input  logic [size-1:0]          Constant_in,
    output logic [size-1:0]          Addr_out,
    output logic [size-1:0]          Data_out,
    output logic                     C,
    output logic                     V,
    output logic                     N,
    output logic                     Z
);

    // Control is applied cycle-by-cycle with no valid/ready handshake: every
    // operation is complete at the next rising edge of clk.
    localparam int NREG = size;

    logic [size-1:0] regs [NREG];
    logic [size-1:0] reg_a;
    logic [size-1:0] reg_b;
    logic [size-1:0] op_a;
    logic [size-1:0] op_b;
    logic [size-1:0] alu_result;
    logic [size-1:0] wb_data;
    flags_t          alu_flags;

    // R0 reads as zero regardless of array contents; writes to it are dropped.
    assign reg_a = (A_select == '0) ? '0 : regs[A_select];
    assign reg_b = (B_select == '0) ? '0 : regs[B_select];

    assign op_a    = MR_select ? PC_in : reg_a;
    assign op_b    = MB_select ? Constant_in : reg_b;
    assign wb_data = MD_select ? Data_in : alu_result;

    assign Addr_out = alu_result;
    assign Data_out = reg_b;

    datapath_alu #(
        .W (size)
    ) u_alu (
        .op_a   (op_a),
        .op_b   (op_b),
        .sel    (Sel),
        .result (alu_result),
        .flags  (alu_flags)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (D_addr != '0)) begin
            regs[D_addr] <= wb_data;
        end
    end

`ifdef DATAPATH_FLAGS_REG_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {C, V, N, Z} <= 4'b0000;
        end else if (we) begin
            {C, V, N, Z} <= {alu_flags.c, alu_flags.v, alu_flags.n, alu_flags.z};
        end
    end
`else
    assign {C, V, N, Z} = {alu_flags.c, alu_flags.v, alu_flags.n, alu_flags.z};
`endif

endmodule

// File: tb/tb_datapath_core.sv
// Directed bench for datapath_core: driver pushes hand-computed results, a negedge monitor checks them.
module tb_datapath_core;
    import datapath_pkg::*;

    logic        clk;
    logic        reset;
    logic        we;
    logic        MB_select;
    logic        MD_select;
    logic        MR_select;
    logic [3:0]  Sel;
    logic [4:0]  A_select;
    logic [4:0]  B_select;
    logic [4:0]  D_addr;
    logic [31:0] PC_in;
    logic [31:0] Data_in;
    logic [31:0] Constant_in;
    logic [31:0] Addr_out;
    logic [31:0] Data_out;
    logic        C;
    logic        V;
    logic        N;
    logic        Z;

    logic [67:0] exp_q[$];
    string       name_q[$];
    int          n_cmp;
    int          n_fail;

    datapath_core dut (
        .clk         (clk),
        .reset       (reset),
        .we          (we),
        .MB_select   (MB_select),
        .MD_select   (MD_select),
        .MR_select   (MR_select),
        .Sel         (Sel),
        .A_select    (A_select),
        .B_select    (B_select),
        .D_addr      (D_addr),
        .PC_in       (PC_in),
        .Data_in     (Data_in),
        .Constant_in (Constant_in),
        .Addr_out    (Addr_out),
        .Data_out    (Data_out),
        .C           (C),
        .V           (V),
        .N           (N),
        .Z           (Z)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    task automatic drive(input logic w, input logic mb, input logic md, input logic mr,
                         input logic [3:0] sel, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input logic [31:0] pc, input logic [31:0] din,
                         input logic [31:0] k);
        we = w; MB_select = mb; MD_select = md; MR_select = mr;
        Sel = sel; A_select = a; B_select = b; D_addr = d;
        PC_in = pc; Data_in = din; Constant_in = k;
    endtask

    task automatic expect_out(input string nm, input logic [31:0] ad, input logic [31:0] dt,
                              input logic [3:0] cvnz);
        exp_q.push_back({ad, dt, cvnz});
        name_q.push_back(nm);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Loads val into register r through the Data_in write-back path; ALU sees 0+0.
    task automatic load(input logic [4:0] r, input logic [31:0] val);
        drive(1, 1, 1, 0, ALU_ADD, 5'd0, 5'd0, r, 32'h0, val, 32'h0);
        expect_out("load", 32'h0, 32'h0, 4'b0001);
        step();
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        logic [67:0] e;
        logic [67:0] got;
        string       nm;
        if (exp_q.size() != 0) begin
            e   = exp_q.pop_front();
            nm  = name_q.pop_front();
            got = {Addr_out, Data_out, C, V, N, Z};
`ifdef DATAPATH_FLAGS_REG_EN
            got[3:0] = e[3:0];
`endif
            n_cmp++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL %s: got addr=%h data=%h cvnz=%b, required addr=%h data=%h cvnz=%b",
                         nm, got[67:36], got[35:4], got[3:0], e[67:36], e[35:4], e[3:0]);
            end
        end
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b0;
        drive(0, 0, 0, 0, ALU_ADD, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // 1. reset state
        drive(0, 0, 0, 0, ALU_ADD, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        expect_out("reset_state", 32'h0, 32'h0, 4'b0001);
        step();

        // 2. load R1=7 through Data_in; ALU shows 0+1
        drive(1, 1, 1, 0, ALU_ADD, 5'd0, 5'd0, 5'd1, 32'h0, 32'h7, 32'h1);
        expect_out("load_r1_addr", 32'h1, 32'h0, 4'b0000);
        step();

        // 3. R1-R1 written back to R1
        drive(1, 0, 0, 0, ALU_SUB, 5'd1, 5'd1, 5'd1, 32'h0, 32'h0, 32'h0);
        expect_out("sub_clear", 32'h0, 32'h7, 4'b1001);
        step();
        drive(0, 0, 0, 0, ALU_ADD, 5'd1, 5'd1, 5'd0, 32'h0, 32'h0, 32'h0);
        expect_out("r1_cleared", 32'h0, 32'h0, 4'b0001);
        step();
        drive(1, 1, 1, 0, ALU_ADD, 5'd0, 5'd0, 5'd0, 32'h0, 32'hDEAD_BEEF, 32'h0);
        expect_out("write_r0", 32'h0, 32'h0, 4'b0001);
        step();
        drive(0, 0, 0, 0, ALU_ADD, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        expect_out("r0_still_zero", 32'h0, 32'h0, 4'b0001);
        step();

        // 4. shifts; shift amount 0x21 uses only its low five bits
        load(5'd1, 32'h5);
        drive(0, 1, 0, 0, ALU_SLL, 5'd1, 5'd1, 5'd0, 32'h0, 32'h0, 32'h21);
        expect_out("sll", 32'hA, 32'h5, 4'b0000);
        step();
        load(5'd1, 32'h8000_0000);
        drive(0, 1, 0, 0, ALU_SRA, 5'd1, 5'd1, 5'd0, 32'h0, 32'h0, 32'h4);
        expect_out("sra", 32'hF800_0000, 32'h8000_0000, 4'b0010);
        step();
        drive(0, 1, 0, 0, ALU_SRL, 5'd1, 5'd1, 5'd0, 32'h0, 32'h0, 32'h4);
        expect_out("srl", 32'h0800_0000, 32'h8000_0000, 4'b0000);
        step();

        // 5. overflow, borrow and compares
        load(5'd1, 32'h7FFF_FFFF);
        load(5'd3, 32'h1);
        drive(0, 0, 0, 0, ALU_ADD, 5'd1, 5'd3, 5'd0, 32'h0, 32'h0, 32'h0);
        expect_out("add_ovf", 32'h8000_0000, 32'h1, 4'b0110);
        step();
        drive(0, 0, 0, 0, ALU_SUB, 5'd0, 5'd3, 5'd0, 32'h0, 32'h0, 32'h0);
        expect_out("sub_borrow", 32'hFFFF_FFFF, 32'h1, 4'b0010);
        step();
        drive(0, 1, 0, 0, ALU_SLT, 5'd3, 5'd0, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFFF);
        expect_out("slt_1_m1", 32'h0, 32'h0, 4'b0001);
        step();
        drive(0, 1, 0, 0, ALU_SLTU, 5'd3, 5'd0, 5'd0, 32'h0, 32'h0, 32'hFFFF_FFFF);
        expect_out("sltu_1_max", 32'h1, 32'h0, 4'b0000);
        step();
        drive(0, 1, 0, 1, ALU_SLT, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFF0, 32'h0, 32'h1);
        expect_out("slt_neg", 32'h1, 32'h0, 4'b1000);
        step();
        drive(0, 1, 0, 1, ALU_SLTU, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFF0, 32'h0, 32'h1);
        expect_out("sltu_big", 32'h0, 32'h0, 4'b1001);
        step();
        drive(0, 1, 0, 0, ALU_XOR, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0F0F_0F0F);
        expect_out("xor", 32'h70F0_F0F0, 32'h0, 4'b0000);
        step();
        drive(0, 1, 0, 0, ALU_OR, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0F0F_0F0F);
        expect_out("or", 32'h7FFF_FFFF, 32'h0, 4'b0000);
        step();
        drive(0, 1, 0, 0, ALU_AND, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0F0F_0F0F);
        expect_out("and", 32'h0F0F_0F0F, 32'h0, 4'b0000);
        step();
        drive(0, 1, 0, 1, ALU_ADD, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h1);
        expect_out("add_carry", 32'h0, 32'h0, 4'b1001);
        step();
        drive(0, 1, 0, 1, ALU_SUB, 5'd0, 5'd0, 5'd0, 32'h8000_0000, 32'h0, 32'h1);
        expect_out("sub_ovf", 32'h7FFF_FFFF, 32'h0, 4'b1100);
        step();
        drive(0, 1, 0, 0, 4'b0111, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0, 32'h1234);
        expect_out("pass_0111", 32'h1234, 32'h0, 4'b0000);
        step();

        // 6. PC mux, write/read same register, async reset
        drive(0, 1, 0, 1, ALU_ADD, 5'd0, 5'd0, 5'd0, 32'h100, 32'h0, 32'h20);
        expect_out("pc_mux", 32'h120, 32'h0, 4'b0000);
        step();
        drive(1, 1, 0, 0, ALU_ADD, 5'd0, 5'd2, 5'd2, 32'h0, 32'h0, 32'h55);
        expect_out("wr_rd_old", 32'h55, 32'h0, 4'b0000);
        step();
        drive(0, 0, 0, 0, ALU_ADD, 5'd0, 5'd2, 5'd0, 32'h0, 32'h0, 32'h0);
        expect_out("wr_rd_new", 32'h55, 32'h55, 4'b0000);
        step();
        drive(0, 0, 0, 0, ALU_ADD, 5'd1, 5'd3, 5'd0, 32'h0, 32'h0, 32'h0);
        reset = 1'b0;
        expect_out("async_reset", 32'h0, 32'h0, 4'b0001);
        step();
        reset = 1'b1;
        drive(0, 0, 0, 0, ALU_ADD, 5'd1, 5'd2, 5'd0, 32'h0, 32'h0, 32'h0);
        expect_out("after_reset", 32'h0, 32'h0, 4'b0001);
        step();

        // Final report
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
